l1_lower_memory_responder: RTL



---
 rtl/l1_lower_memory_responder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/l1_lower_memory_responder.sv
// Fixed-latency word memory serving L1 D-cache fills and writebacks.
// Define MEM_RESP_ERR_EN to flag out-of-range addresses on mem_error.
module l1_lower_memory_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 4,
  parameter int ADDR_LSB    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_request,
  input  logic        mem_write_enable,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_response_data,
  output logic        mem_ready,
  output logic        busy
`ifdef MEM_RESP_ERR_EN
  ,
  output logic        mem_error
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND,
    RELEASE
  } state_e;

  state_e        state_q;
  logic [7:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic          oor_q;
  logic          oor_d;
  logic [31:0]   rdata_q;
  logic          ready_q;
  logic          done;
  logic          commit;

  logic [31:0] mem_q [DEPTH_WORDS];

`ifdef MEM_RESP_ERR_EN
  logic err_q;
  assign oor_d     = |(mem_address >> (ADDR_LSB + AW));
  assign mem_error = err_q;
`else
  assign oor_d = 1'b0;
`endif

  assign done   = (state_q == WAIT) && (cnt_q == 8'd0);
  assign commit = done && we_q && !oor_q;

  // Storage is not reset; reset only cancels the pending commit.
  always_ff @(posedge clk) begin
    if (commit) mem_q[idx_q] <= wdata_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      oor_q   <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
`ifdef MEM_RESP_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
`ifdef MEM_RESP_ERR_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (mem_request) begin
            idx_q   <= mem_address[ADDR_LSB +: AW];
            we_q    <= mem_write_enable;
            wdata_q <= mem_write_data;
            oor_q   <= oor_d;
            cnt_q   <= 8'(LATENCY - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == 8'd0) begin
            state_q <= RESPOND;
            ready_q <= 1'b1;
`ifdef MEM_RESP_ERR_EN
            err_q   <= oor_q;
`endif
            if (!we_q)
              rdata_q <= oor_q ? 32'hDEAD_BEEF : mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RESPOND: begin
          // An aborted request has already dropped: skip RELEASE.
          state_q <= mem_request ? RELEASE : IDLE;
        end
        RELEASE: begin
          if (!mem_request) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_response_data = rdata_q;
  assign mem_ready         = ready_q;
  assign busy              = (state_q != IDLE);

endmodule
